// File: rtl/io_bridge_pkg.sv
// Shared definitions for the CPU-to-IO bridge.
//   state_e          : bridge FSM state encoding (also exported on dbg_state)
//   ERR_DATA_DEFAULT : read data returned on an errored read (all zero);
//                      sliced down to DATA_W by the top, so DATA_W <= 256
//   sel_width()      : width of the slave-select field for N slaves
package io_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ERR_DATA_DEFAULT = '0;

  function automatic int sel_width(input int n_slv);
    return (n_slv <= 1) ? 1 : $clog2(n_slv);
  endfunction

endpackage

// File: rtl/axi_io_bridge_mc_if.sv
// CPU request/response bus and IO slave bus of the bridge.
//   slave  modport : the bridge's view (accepts CPU requests, drives IO side)
//   master modport : the environment's view (CPU plus IO slaves)
// Handshake: a request transfers on a rising edge where its valid and ready
// are both 1; ready never depends on the same channel's valid, and the
// requester holds valid and payload steady until the transfer. bvalid/rvalid
// are single-cycle pulses with no back-pressure.
interface axi_io_bridge_mc_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 4
) ();
  localparam int BE_W = DATA_W / 8;

  logic                    wvalid;
  logic                    wready;
  logic [ADDR_W-1:0]       awaddr;
  logic [DATA_W-1:0]       wdata;
  logic [BE_W-1:0]         wstrb;
  logic                    bvalid;
  logic                    berr;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_W-1:0]       araddr;
  logic                    rvalid;
  logic                    rerr;
  logic [DATA_W-1:0]       rdata;
  logic [N_SLV-1:0]        io_sel;
  logic                    io_addr_strobe;
  logic                    io_read_strobe;
  logic                    io_write_strobe;
  logic [ADDR_W-1:0]       io_addr;
  logic [BE_W-1:0]         io_byte_enable;
  logic [DATA_W-1:0]       io_write_data;
  logic [N_SLV*DATA_W-1:0] io_read_data;
  logic [N_SLV-1:0]        io_ready;

  modport slave (
    input  wvalid, awaddr, wdata, wstrb, arvalid, araddr, io_read_data, io_ready,
    output wready, bvalid, berr, arready, rvalid, rerr, rdata,
           io_sel, io_addr_strobe, io_read_strobe, io_write_strobe,
           io_addr, io_byte_enable, io_write_data
  );

  modport master (
    output wvalid, awaddr, wdata, wstrb, arvalid, araddr, io_read_data, io_ready,
    input  wready, bvalid, berr, arready, rvalid, rerr, rdata,
           io_sel, io_addr_strobe, io_read_strobe, io_write_strobe,
           io_addr, io_byte_enable, io_write_data
  );
endinterface

// File: rtl/io_addr_decode.sv
// Address decoder: maps a CPU address to an IO slave.
//   addr   in  : request address
//   idx    out : slave index, addr[SEL_LSB +: SEL_W]
//   onehot out : one-hot slave select, zero when unmapped
//   mapped out : address falls on an existing slave
// The slave region number is everything from SEL_LSB upwards, so any set bit
// above the select field also makes the address unmapped (0x5000_0000 with
// four slaves is region 5, not slave 1).
module io_addr_decode
  import io_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int N_SLV   = 4,
  parameter int SEL_LSB = 28,
  localparam int SEL_W  = sel_width(N_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  idx,
  output logic [N_SLV-1:0]  onehot,
  output logic              mapped
);
  localparam int                TOP_LSB = SEL_LSB + SEL_W;
  localparam logic [N_SLV-1:0]  ONE     = N_SLV'(1);

  logic [ADDR_W-1:0] upper;

  always_comb begin
    idx    = addr[SEL_LSB +: SEL_W];
    upper  = addr >> TOP_LSB;
    mapped = (upper == '0) && (int'(idx) < N_SLV);
    onehot = mapped ? (ONE << idx) : '0;
  end
endmodule

// File: rtl/axi_io_bridge_mc.sv
// CPU-to-IO bridge: accepts one CPU read or write at a time, decodes the
// target slave, strobes it for one cycle, waits (bounded) for its io_ready
// and returns a single-cycle response with an error flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : CPU request/response and IO slave signals (slave modport)
//   dbg_state  : current FSM state
// A write wins when wvalid and arvalid arrive together; the read is taken
// in the next IDLE cycle. Minimum access is accept, strobe, response.
module axi_io_bridge_mc
  import io_bridge_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               N_SLV    = 4,
  parameter int               SEL_LSB  = 28,
  parameter int               TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT[DATA_W-1:0]
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_io_bridge_mc_if.slave  bus,
  output state_e             dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = sel_width(N_SLV);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [N_SLV-1:0]  sel_q;
  logic [SEL_W-1:0]  idx_q;
  logic              is_read_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       cnt_q;

  logic              accept;
  logic [ADDR_W-1:0] req_addr;
  logic [SEL_W-1:0]  dec_idx;
  logic [N_SLV-1:0]  dec_onehot;
  logic              dec_mapped;
  logic              hit;
  logic [15:0]       cnt_inc;
  logic              expired;
  logic [DATA_W-1:0] slv_rdata;

  assign accept   = (state_q == ST_IDLE) && (bus.wvalid || bus.arvalid);
  assign req_addr = bus.wvalid ? bus.awaddr : bus.araddr;

  io_addr_decode #(
    .ADDR_W (ADDR_W),
    .N_SLV  (N_SLV),
    .SEL_LSB(SEL_LSB)
  ) u_decode (
    .addr  (req_addr),
    .idx   (dec_idx),
    .onehot(dec_onehot),
    .mapped(dec_mapped)
  );

  // Only the captured slave's ready/data matter; STROBE/WAIT are entered
  // for mapped slaves only, so idx_q is always in range there.
  assign hit       = bus.io_ready[idx_q];
  assign slv_rdata = bus.io_read_data[int'(idx_q) * DATA_W +: DATA_W];
  assign cnt_inc   = cnt_q + 16'd1;
  assign expired   = (cnt_inc == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = dec_mapped ? ST_STROBE : ST_RESP;
      ST_STROBE: state_d = hit ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (hit || expired) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          addr_q    <= req_addr;
          idx_q     <= dec_idx;
          sel_q     <= dec_onehot;
          is_read_q <= !bus.wvalid;
          err_q     <= !dec_mapped;
          cnt_q     <= '0;
          if (bus.wvalid) begin
            wdata_q <= bus.wdata;
            be_q    <= bus.wstrb;
          end else begin
            be_q    <= '1;
            if (!dec_mapped) rdata_q <= ERR_DATA;
          end
        end
        ST_STROBE: if (hit && is_read_q) rdata_q <= slv_rdata;
        ST_WAIT: begin
          cnt_q <= cnt_inc;
          if (hit) begin
            if (is_read_q) rdata_q <= slv_rdata;
          end else if (expired) begin
            err_q <= 1'b1;
            if (is_read_q) rdata_q <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wready          = (state_q == ST_IDLE);
  assign bus.arready         = (state_q == ST_IDLE) && !bus.wvalid;
  assign bus.bvalid          = (state_q == ST_RESP) && !is_read_q;
  assign bus.berr            = (state_q == ST_RESP) && !is_read_q && err_q;
  assign bus.rvalid          = (state_q == ST_RESP) && is_read_q;
  assign bus.rerr            = (state_q == ST_RESP) && is_read_q && err_q;
  assign bus.rdata           = rdata_q;
  assign bus.io_sel          = (state_q == ST_STROBE || state_q == ST_WAIT) ? sel_q : '0;
  assign bus.io_addr_strobe  = (state_q == ST_STROBE);
  assign bus.io_read_strobe  = (state_q == ST_STROBE) && is_read_q;
  assign bus.io_write_strobe = (state_q == ST_STROBE) && !is_read_q;
  assign bus.io_addr         = addr_q;
  assign bus.io_byte_enable  = be_q;
  assign bus.io_write_data   = wdata_q;
  assign dbg_state           = state_q;
endmodule

// File: tb/tb_axi_io_bridge_mc.sv
// Directed bench for axi_io_bridge_mc (4 slaves, TIMEOUT 8, ERR_DATA
// 0xDEAD_BEEF). Inputs change and outputs are observed on the falling edge.
module tb_axi_io_bridge_mc;
  import io_bridge_pkg::*;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  axi_io_bridge_mc_if #(.ADDR_W(32), .DATA_W(32), .N_SLV(4)) bus ();

  axi_io_bridge_mc #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .N_SLV   (4),
    .SEL_LSB (28),
    .TIMEOUT (8),
    .ERR_DATA(ERR_DATA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // vector: wr, addr, data (write data or slave read data), strb, slave,
  // ready delay (0 = in STROBE, k = k-th WAIT cycle, -1 = never),
  // expected io_sel, response latency from accept, err, read data
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          slv;
    int          dly;
    logic [3:0]  sel;
    int          lat;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[8];

  task automatic fill_read_data(input int slv, input logic [31:0] d);
    for (int k = 0; k < 4; k++) bus.io_read_data[k*32 +: 32] = {8'(k), 24'h5A_C3E1};
    bus.io_read_data[slv*32 +: 32] = d;
  endtask

  // driver + checker for one access, entered and left on a falling edge
  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] noise;
    int         strobes;
    bit         done;
    noise   = v.sel[3] ? 4'b0001 : 4'b1000;
    strobes = 0;
    done    = 1'b0;
    fill_read_data(v.slv, v.data);
    bus.awaddr  = v.addr;
    bus.araddr  = v.addr;
    bus.wdata   = v.data;
    bus.wstrb   = v.strb;
    bus.wvalid  = v.wr;
    bus.arvalid = !v.wr;
    #1;
    if (v.wr) chk({tag, " wready"}, bus.wready, 1'b1);
    else      chk({tag, " arready"}, bus.arready, 1'b1);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      bus.wvalid   = 1'b0;
      bus.arvalid  = 1'b0;
      bus.io_ready = noise;
      if (v.dly >= 0 && c == 1 + v.dly) bus.io_ready[v.slv] = 1'b1;
      #1;
      if (bus.io_addr_strobe) begin
        strobes++;
        chk({tag, " write_strobe"}, bus.io_write_strobe, v.wr);
        chk({tag, " read_strobe"}, bus.io_read_strobe, !v.wr);
        chk({tag, " byte_enable"}, bus.io_byte_enable, v.wr ? v.strb : 4'hF);
        if (v.wr) chk({tag, " write_data"}, bus.io_write_data, v.data);
      end
      if (bus.bvalid || bus.rvalid) begin
        done = 1'b1;
        chk({tag, " latency"}, c, v.lat);
        chk({tag, " bvalid"}, bus.bvalid, v.wr);
        chk({tag, " rvalid"}, bus.rvalid, !v.wr);
        chk({tag, " err"}, v.wr ? bus.berr : bus.rerr, v.err);
        chk({tag, " resp_sel"}, bus.io_sel, 4'b0000);
        if (!v.wr) last_rd = v.rd;
        chk({tag, " rdata"}, bus.rdata, last_rd);
      end else begin
        chk({tag, " io_sel"}, bus.io_sel, v.sel);
        chk({tag, " io_addr"}, bus.io_addr, v.addr);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s no response within 40 cycles", tag);
    end
    chk({tag, " strobe_count"}, strobes, (v.sel != 4'b0000) ? 1 : 0);
    @(negedge clk);
    bus.io_ready = '0;
    #1;
    chk({tag, " resp_one_cycle"}, {bus.bvalid, bus.rvalid}, 2'b00);
    chk({tag, " back_idle"}, bus.wready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 1,  2, 4'b0010,  4, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h2000_0000, 32'hCAFE_F00D, 4'h0, 2,  0, 4'b0100,  2, 1'b0, 32'hCAFE_F00D};
    vecs[2] = '{1'b0, 32'h5000_0000, 32'h0000_0000, 4'h0, 0, -1, 4'b0000,  1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h0000_0010, 32'h0000_0001, 4'hF, 0, -1, 4'b0001, 10, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h3000_0008, 32'h1234_5678, 4'h0, 3,  5, 4'b1000,  7, 1'b0, 32'h1234_5678};
    vecs[5] = '{1'b1, 32'h1000_0000, 32'hFFFF_0000, 4'hC, 1,  8, 4'b0010, 10, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0100, 32'h0BAD_CAFE, 4'h0, 0, -1, 4'b0001, 10, 1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 32'h2000_00FC, 32'h0F0F_0F0F, 4'h0, 2,  0, 4'b0100,  2, 1'b0, 32'h0};

    last_rd      = '0;
    rst_n        = 1'b0;
    bus.wvalid   = 1'b0;
    bus.arvalid  = 1'b0;
    bus.awaddr   = '0;
    bus.araddr   = '0;
    bus.wdata    = '0;
    bus.wstrb    = '0;
    bus.io_ready = '0;
    fill_read_data(0, 32'h0);

    // reset state
    #3;
    chk("rst wready", bus.wready, 1'b1);
    chk("rst arready", bus.arready, 1'b1);
    chk("rst outputs", {bus.bvalid, bus.berr, bus.rvalid, bus.rerr, bus.io_sel,
                        bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 11'd0);
    chk("rst io_addr", bus.io_addr, 32'h0);
    chk("rst byte_enable", bus.io_byte_enable, 4'h0);
    chk("rst rdata", bus.rdata, 32'h0);
    chk("rst state", dbg_state, ST_IDLE);
    bus.wvalid = 1'b1;
    #1;
    chk("rst arready_wvalid", bus.arready, 1'b0);
    bus.wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven accesses
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // simultaneous write and read: write first, read in next IDLE
    fill_read_data(2, 32'h7777_8888);
    bus.io_ready = 4'b0110;
    bus.awaddr   = 32'h1000_0008;
    bus.wdata    = 32'h1111_2222;
    bus.wstrb    = 4'hF;
    bus.araddr   = 32'h2000_0004;
    bus.wvalid   = 1'b1;
    bus.arvalid  = 1'b1;
    #1;
    chk("both wready", bus.wready, 1'b1);
    chk("both arready_blocked", bus.arready, 1'b0);
    @(negedge clk);
    bus.wvalid = 1'b0;
    #1;
    chk("both wr_strobe", {bus.io_write_strobe, bus.io_read_strobe}, 2'b10);
    chk("both wr_sel", bus.io_sel, 4'b0010);
    chk("both wr_addr", bus.io_addr, 32'h1000_0008);
    chk("both arready_busy", bus.arready, 1'b0);
    @(negedge clk); #1;
    chk("both bresp", {bus.bvalid, bus.berr, bus.rvalid}, 3'b100);
    @(negedge clk); #1;
    chk("both read_accept", bus.arready, 1'b1);
    chk("both idle_quiet", {bus.bvalid, bus.rvalid}, 2'b00);
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1;
    chk("both rd_strobe", {bus.io_write_strobe, bus.io_read_strobe}, 2'b01);
    chk("both rd_sel", bus.io_sel, 4'b0100);
    chk("both rd_addr", bus.io_addr, 32'h2000_0004);
    chk("both rd_be", bus.io_byte_enable, 4'hF);
    @(negedge clk); #1;
    chk("both rresp", {bus.rvalid, bus.rerr, bus.bvalid}, 3'b100);
    chk("both rdata", bus.rdata, 32'h7777_8888);
    @(negedge clk); #1;
    chk("both done", {bus.bvalid, bus.rvalid}, 2'b00);
    bus.io_ready = '0;

    // reset pulse while waiting on a slave
    bus.awaddr = 32'h0000_0020;
    bus.wdata  = 32'h0000_0055;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rstw in_wait", dbg_state, ST_WAIT);
    chk("rstw sel", bus.io_sel, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("rstw state", dbg_state, ST_IDLE);
    chk("rstw outputs", {bus.bvalid, bus.rvalid, bus.io_sel, bus.io_addr_strobe}, 7'd0);
    chk("rstw wready", bus.wready, 1'b1);
    chk("rstw rdata", bus.rdata, 32'h0);
    chk("rstw io_addr", bus.io_addr, 32'h0);
    last_rd      = '0;
    bus.io_ready = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      chk("rstw no_resp", {bus.bvalid, bus.rvalid, bus.io_addr_strobe}, 3'b000);
    end
    bus.io_ready = '0;
    @(negedge clk);
    run_vec(vecs[1], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
